// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared FSM encoding and activation constants for activation_fifo
package activation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Leaky slope is 1/8, realised as an arithmetic right shift.
    localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/activation_fifo_if.sv
// rtl/activation_fifo_if.sv - PE-result input stream and pooling read port of activation_fifo
interface activation_fifo_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PE     = 4
);
    logic [DATA_WIDTH*NUM_PE-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH*NUM_PE-1:0] read_data;
    logic                         read_ready;
    logic                         read_req;

    modport master (
        output in_data, in_valid, read_req,
        input  in_ready, read_data, read_ready
    );

    modport slave (
        input  in_data, in_valid, read_req,
        output in_ready, read_data, read_ready
    );
endinterface

// File: rtl/activation_fifo_mem.sv
// rtl/activation_fifo_mem.sv - parameterised show-ahead FIFO with occupancy-based full/empty
module activation_fifo_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_wr;
    logic             do_rd;

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Head is forced to zero while empty so the read port is clean out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/activation_fifo.sv
// rtl/activation_fifo.sv - job FSM plus ReLU at FIFO write; define LEAKY_RELU_EN for leaky ReLU
module activation_fifo
    import activation_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_PE      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_words,
    input  logic                   cfg,
    activation_fifo_if.slave       bus,
    output logic                   done
);
    localparam int WORD_W = DATA_WIDTH * NUM_PE;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] words_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   cfg_q;
    logic                   done_zero_q, done_zero_d;
    logic                   job_start;
    logic                   accept;
    logic                   last_word;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [WORD_W-1:0]      act_word;

    assign bus.in_ready   = (state_q == RUN) && !fifo_full;
    assign bus.read_ready = !fifo_empty;
    assign accept         = bus.in_valid && bus.in_ready;
    assign last_word      = (cnt_q == words_q - COUNT_WIDTH'(1));
    assign done           = !reset && (done_zero_q || ((state_q == DRAIN) && fifo_empty));

    always_comb begin
        state_d     = state_q;
        done_zero_d = 1'b0;
        job_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        done_zero_d = 1'b1;
                    end else begin
                        job_start = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN:     if (accept && last_word) state_d = DRAIN;
            DRAIN:   if (fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            words_q     <= '0;
            cnt_q       <= '0;
            cfg_q       <= 1'b0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_zero_q <= done_zero_d;
            if (job_start) begin
                words_q <= num_words;
                cfg_q   <= cfg;
                cnt_q   <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Activation is applied before the write so the FIFO holds final values.
    always_comb begin
        act_word = bus.in_data;
        if (cfg_q) begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (bus.in_data[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
`ifdef LEAKY_RELU_EN
                    act_word[i*DATA_WIDTH +: DATA_WIDTH] =
                        $signed(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]) >>> LEAKY_SHIFT;
`else
                    act_word[i*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
                end
            end
        end
    end

    activation_fifo_mem #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (act_word),
        .rd_en   (bus.read_req),
        .rd_data (bus.read_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_activation_fifo.sv
// tb/tb_activation_fifo.sv - scoreboard bench for activation_fifo (honours LEAKY_RELU_EN)
module tb_activation_fifo;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] num_words;
    logic        cfg;
    logic        done;

    activation_fifo_if #(.DATA_WIDTH(16), .NUM_PE(4)) bus ();

    activation_fifo #(
        .DATA_WIDTH  (16),
        .NUM_PE      (4),
        .FIFO_DEPTH  (8),
        .COUNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .cfg       (cfg),
        .bus       (bus),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb_q   [$];
    logic [63:0] stim_q [$];
    logic [63:0] exp_q  [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] act_model(input logic [63:0] w, input bit c);
        logic signed [15:0] l;
        act_model = w;
        if (c) begin
            for (int i = 0; i < 4; i++) begin
                l = w[i*16 +: 16];
                if (l < 0) begin
`ifdef LEAKY_RELU_EN
                    act_model[i*16 +: 16] = l >>> 3;
`else
                    act_model[i*16 +: 16] = 16'h0000;
`endif
                end
            end
        end
    endfunction

    task automatic run_job(input int n, input bit c, input int hold, input bit full_test);
        int          sent, pops, cyc;
        bit          got_done, lat_pending, first_pop_seen, post_pop_chk, full_chk_done;
        logic [63:0] lat_exp, e;
        sent = 0; pops = 0; cyc = 0;
        got_done = 0; lat_pending = 0; first_pop_seen = 0; post_pop_chk = 0; full_chk_done = 0;
        sb_q.delete();
        @(posedge clk); #1;
        start = 1'b1; num_words = 16'(n); cfg = c;
        bus.in_valid = 1'b0; bus.read_req = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && cyc < 1000) begin
            bus.in_valid = (sent < n);
            bus.in_data  = (sent < n) ? stim_q[sent] : 64'h0;
            bus.read_req = (cyc >= hold);
            @(negedge clk);
            if (lat_pending) begin
                check("latency_ready", bus.read_ready, 1);
                check("latency_data", bus.read_data, lat_exp);
                lat_pending = 0;
            end
            if (post_pop_chk) begin
                check("ready_after_pop", bus.in_ready, 1);
                post_pop_chk = 0;
            end
            if (full_test && !full_chk_done && bus.in_valid && !bus.in_ready) begin
                check("accepts_at_full", sent, 8);
                full_chk_done = 1;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(exp_q[sent]);
                if (!bus.read_ready) begin
                    lat_pending = 1;
                    lat_exp     = exp_q[sent];
                end
                sent++;
            end
            if (bus.read_req && bus.read_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("pop_data", bus.read_data, e);
                end
                if (full_test && !first_pop_seen) begin
                    first_pop_seen = 1;
                    check("ready_low_at_full_pop", bus.in_ready, 0);
                    post_pop_chk = 1;
                end
                pops++;
            end
            if (done) begin
                got_done = 1;
                check("done_after_pops", pops, n);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", got_done, 1);
        check("sb_empty", sb_q.size(), 0);
        if (full_test) check("full_reached", full_chk_done, 1);
        bus.in_valid = 1'b0;
        bus.read_req = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        int          dcount;
        reset = 1'b1; start = 1'b0; num_words = '0; cfg = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.read_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_read_ready", bus.read_ready, 0);
        check("rst_done", done, 0);
        check("rst_read_data", bus.read_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ReLU on: {-5,7,0,-32768}
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(64'h8000_0000_0007_FFFB);
`ifdef LEAKY_RELU_EN
        exp_q.push_back(64'hF000_0000_0007_FFFF);
`else
        exp_q.push_back(64'h0000_0000_0007_0000);
`endif
        for (int k = 0; k < 2; k++) begin
            r = {$urandom(), $urandom()};
            stim_q.push_back(r);
            exp_q.push_back(act_model(r, 1));
        end
        run_job(3, 1, 0, 0);

        // bypass: same word unchanged
        stim_q.delete(); exp_q.delete();
        stim_q.push_back(64'h8000_0000_0007_FFFB);
        exp_q.push_back(64'h8000_0000_0007_FFFB);
        run_job(1, 0, 0, 0);

        // backpressure: 20 words with pops held off
        stim_q.delete(); exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            r = {$urandom(), $urandom()};
            stim_q.push_back(r);
            exp_q.push_back(act_model(r, 1));
        end
        run_job(20, 1, 15, 1);

        // negative-lane boundaries
        stim_q.delete(); exp_q.delete();
`ifdef LEAKY_RELU_EN
        stim_q.push_back(64'h0000_0064_FFFF_FFC0);
        exp_q.push_back(64'h0000_0064_FFFF_FFF8);
`else
        stim_q.push_back(64'hFFFE_8000_FFC0_FFFF);
        exp_q.push_back(64'h0000_0000_0000_0000);
`endif
        stim_q.push_back(64'h7FFF_0001_0000_8001);
        exp_q.push_back(act_model(64'h7FFF_0001_0000_8001, 1));
        run_job(2, 1, 3, 0);

        // zero-length job
        @(posedge clk); #1;
        start = 1'b1; num_words = 16'd0; cfg = 1'b1;
        @(negedge clk);
        check("zero_done_early", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done_pulse", done, 1);
        check("zero_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done_width", done, 0);
        check("zero_in_ready_after", bus.in_ready, 0);

        // reset with 5 words buffered
        @(posedge clk); #1;
        start = 1'b1; num_words = 16'd10; cfg = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(k + 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_read_ready", bus.read_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_read_ready", bus.read_ready, 0);
        check("post_reset_in_ready", bus.in_ready, 0);
        check("post_reset_read_data", bus.read_data, 0);
        dcount = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check("post_reset_no_done", dcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/activation_fifo.md
ACTIVATION_FIFO -- requirements
Module: activation_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed two's-complement width of one lane.
REQ-002 SHALL have parameter NUM_PE, default 4, meaning lanes per word.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning words of buffering (power of two, >=2).
REQ-004 SHALL have parameter COUNT_WIDTH, default 16, meaning width of the word-count configuration.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle pulse that begins a job.
REQ-008 SHALL have port num_words, input, COUNT_WIDTH, words in the job, sampled on start.
REQ-009 SHALL have port cfg, input, 1, 1 = activation on, 0 = bypass, sampled on start.
REQ-010 SHALL have port in_data, input, DATA_WIDTH*NUM_PE, PE result word; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port in_valid, input, 1, in_data is valid.
REQ-012 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-013 SHALL have port read_data, output, DATA_WIDTH*NUM_PE, FIFO head word going to pooling.
REQ-014 SHALL have port read_ready, output, 1, read_data is valid (FIFO not empty).
REQ-015 SHALL have port read_req, input, 1, pooling pops the head word.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at job completion.

Function
REQ-017 SHALL implement states IDLE, RUN and DRAIN.
REQ-018 SHALL transition IDLE->RUN on start with num_words>0, latching num_words and cfg.
REQ-019 SHALL, on start with num_words==0, pulse done on the next cycle and remain in IDLE.
REQ-020 SHALL ignore start while in RUN or DRAIN.
REQ-021 SHALL drive in_ready = (state==RUN) && !full.
REQ-022 SHALL write one word on in_valid && in_ready and increment the accepted-word count.
REQ-023 SHALL transition RUN->DRAIN on the cycle the num_words-th word is accepted.
REQ-024 SHALL transition DRAIN->IDLE when the FIFO is empty and pulse done in that same cycle.
REQ-025 SHALL, when the latched cfg is 1, apply the per-lane activation at the FIFO write: negative lane -> 0, non-negative lane unchanged.
REQ-026 SHALL, when the latched cfg is 0, store lanes unmodified.
REQ-027 SHALL have latency 1: a word accepted in cycle N appears at read_data with read_ready=1 in cycle N+1 (show-ahead FIFO).
REQ-028 SHALL pop the head on read_req && read_ready; read_req with read_ready=0 SHALL be ignored (no underflow, no pointer change).
REQ-029 SHALL allow a simultaneous write and pop, leaving occupancy unchanged.
REQ-030 SHALL keep in_ready low when full even if a pop occurs in the same cycle.
REQ-031 SHALL wrap read and write pointers modulo FIFO_DEPTH and track full/empty with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-032 SHALL allow read_data to be any value while read_ready=0.

Reset
REQ-033 SHALL, on reset, enter IDLE, clear pointers, occupancy and word count, and drive in_ready=0, read_ready=0, done=0, read_data=0.
REQ-034 SHALL, on reset asserted mid-job, discard all buffered words; no done pulse is produced for the aborted job.

Configuration
REQ-035 SHALL, with LEAKY_RELU_EN defined and the activation on, replace negative lanes with an arithmetic shift right by 3 (x>>>3) instead of 0.
REQ-036 SHALL, without LEAKY_RELU_EN, implement plain ReLU as in REQ-025.

Structure
REQ-037 SHALL place the state encoding (IDLE/RUN/DRAIN) and the leaky shift constant (3) in a shared package, activation_pkg.
REQ-038 SHALL implement the buffer as sub-module activation_fifo_mem (a parameterised show-ahead FIFO); the activation and the FSM stay in the top level.

Verification
REQ-039 SHALL verify: start with num_words=3 and cfg=1, lanes {-5,7,0,-32768} -> read_data lanes {0,7,0,0} one cycle after accept, and done after 3 pops.
REQ-040 SHALL verify: cfg=0 with the same word -> lanes {-5,7,0,-32768} unchanged.
REQ-041 SHALL verify: num_words=20, read_req held low -> in_ready drops after 8 accepts; in_ready rises again on the first pop; all 20 words are received in order.
REQ-042 SHALL verify: num_words=0 -> done pulses for exactly 1 cycle, one cycle after start, and in_ready stays 0.
REQ-043 SHALL verify: reset asserted with 5 words buffered -> next cycle read_ready=0 and in_ready=0, with no done pulse.
REQ-044 SHALL verify, with LEAKY_RELU_EN defined: lane -64 -> -8 and lane -1 -> -1.
